// File: rtl/notch_error_feedback_requantizer.sv
// Second-order error-feedback requantizer: WIDTH-bit signed samples to an OUT_BITS-bit signed code,
// with quantization noise shaped by NTF(z) = 1 - C1*z^-1 + z^-2 (notch at the filter's centre frequency).
module notch_error_feedback_requantizer #(
  parameter int WIDTH     = 16,
  parameter int OUT_BITS  = 4,
  parameter int COEF_W    = 18,
  parameter int COEF_FRAC = 16,
  parameter int C1        = 124650
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [WIDTH-1:0]    x_in_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [OUT_BITS-1:0] code_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                sat_o
);

  localparam int SHIFT  = WIDTH - OUT_BITS;
  localparam int ACC_W  = WIDTH + 4;
  localparam int ERR_W  = SHIFT + 1;
  localparam int PROD_W = COEF_W + ERR_W;

  localparam logic signed [COEF_W-1:0] C1_S = COEF_W'(C1);
  localparam logic signed [PROD_W:0]   RND  = (PROD_W+1)'(64'sd1 <<< (COEF_FRAC - 1));
  localparam logic signed [ACC_W-1:0]  QMAX = ACC_W'((1 << (OUT_BITS - 1)) - 1);
  localparam logic signed [ACC_W-1:0]  QMIN = ACC_W'(-(1 << (OUT_BITS - 1)));
  localparam logic signed [ACC_W-1:0]  EMAX = ACC_W'((1 << SHIFT) - 1);
  localparam logic signed [ACC_W-1:0]  EMIN = ACC_W'(-(1 << SHIFT));

  // C1*e1 scaled back to integer samples, rounding half up.
  function automatic logic signed [ACC_W-1:0] round_fb(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W:0] t;
    t = (PROD_W+1)'(p) + RND;
    return ACC_W'(t >>> COEF_FRAC);
  endfunction

  function automatic logic signed [OUT_BITS-1:0] sat_code(input logic signed [ACC_W-1:0] v);
    if (v > QMAX)      return OUT_BITS'(QMAX);
    else if (v < QMIN) return OUT_BITS'(QMIN);
    else               return OUT_BITS'(v);
  endfunction

  // Bounding the fed-back error keeps the loop stable when the code clips.
  function automatic logic signed [ERR_W-1:0] clamp_err(input logic signed [ACC_W-1:0] v);
    if (v > EMAX)      return ERR_W'(EMAX);
    else if (v < EMIN) return ERR_W'(EMIN);
    else               return ERR_W'(v);
  endfunction

  logic signed [ERR_W-1:0]    e1_q, e1_d;
  logic signed [ERR_W-1:0]    e2_q, e2_d;
  logic        [OUT_BITS-1:0] code_q, code_d;
  logic                       sat_q, sat_d;
  logic                       vld_q, vld_d;

  logic                       accept;
  logic signed [WIDTH-1:0]    x_s;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    fb;
  logic signed [ACC_W-1:0]    u;
  logic signed [ACC_W-1:0]    q;
  logic signed [OUT_BITS-1:0] qs;
  logic                       clip;
  logic signed [ACC_W-1:0]    e_full;
  logic signed [ERR_W-1:0]    e_new;

  assign in_ready_o  = !vld_q || out_ready_i;
  assign accept      = in_valid_i && in_ready_o;
  assign code_o      = code_q;
  assign sat_o       = sat_q;
  assign out_valid_o = vld_q;

  assign x_s    = x_in_i;
  assign prod   = PROD_W'(C1_S) * PROD_W'(e1_q);
  assign fb     = round_fb(prod);
  assign u      = ACC_W'(x_s) + fb - ACC_W'(e2_q);
  assign q      = u >>> SHIFT;
  assign qs     = sat_code(q);
  assign clip   = (q > QMAX) || (q < QMIN);
  assign e_full = u - (ACC_W'(qs) <<< SHIFT);
  assign e_new  = clamp_err(e_full);

  always_comb begin
    e1_d   = e1_q;
    e2_d   = e2_q;
    code_d = code_q;
    sat_d  = sat_q;
    vld_d  = vld_q;
    if (accept) begin
      e2_d   = e1_q;
      e1_d   = e_new;
      code_d = qs;
      sat_d  = clip;
      vld_d  = 1'b1;
    end else if (out_ready_i) begin
      vld_d  = 1'b0;
    end
  end

  // Output/loop-state register stage.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      e1_q   <= '0;
      e2_q   <= '0;
      code_q <= '0;
      sat_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      e1_q   <= e1_d;
      e2_q   <= e2_d;
      code_q <= code_d;
      sat_q  <= sat_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: tb/tb_notch_error_feedback_requantizer.sv
// Directed + randomized bench for notch_error_feedback_requantizer with a queue-based scoreboard.
module tb_notch_error_feedback_requantizer;

  localparam longint TB_C1 = 124650;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] x_in = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        sat;
  logic [3:0]  code;

  always #5 clk = ~clk;

  notch_error_feedback_requantizer dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .x_in_i     (x_in),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .code_o     (code),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .sat_o      (sat)
  );

  typedef struct {int code; bit sat;} exp_t;

  exp_t   sb[$];
  int     log_code[$];
  bit     log_sat[$];
  int     ref3[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     n_acc = 0;

  longint m_e1 = 0, m_e2 = 0;
  longint m_fb, m_u, m_q, m_qs, m_e;
  exp_t   pe, ge;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Scoreboard: pop on consume, then run the reference loop and push on accept.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      m_e1 = 0;
      m_e2 = 0;
    end else begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          ge = sb.pop_front();
          check("code", 32'($signed(code)), ge.code);
          check("sat", 32'(sat), 32'(ge.sat));
        end
        log_code.push_back(int'($signed(code)));
        log_sat.push_back(sat);
      end
      if (in_valid && in_ready) begin
        n_acc++;
        m_fb = (TB_C1 * m_e1 + 64'sd32768) >>> 16;
        m_u  = longint'($signed(x_in)) + m_fb - m_e2;
        m_q  = m_u >>> 12;
        m_qs = (m_q > 7) ? 7 : ((m_q < -8) ? -8 : m_q);
        m_e  = m_u - m_qs * 4096;
        if (m_e > 4095)  m_e = 4095;
        if (m_e < -4096) m_e = -4096;
        m_e2 = m_e1;
        m_e1 = m_e;
        pe.code = int'(m_qs);
        pe.sat  = (m_qs != m_q);
        sb.push_back(pe);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (n) tick();
    @(negedge clk);
    check("rst_code", 32'(code), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_sat", 32'(sat), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    log_code.delete();
    log_sat.delete();
  endtask

  task automatic stream(input logic [15:0] x, input int n);
    int start;
    int cyc;
    start = n_acc;
    cyc = 0;
    x_in = x;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while ((n_acc - start) < n && cyc < 4 * n + 20) begin
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("accept_count", n_acc - start, n);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    check("drain", 32'(out_valid), 0);
  endtask

  initial begin
    int sum;
    int oor;

    // Reset held 3 cycles, then an all-zero stream.
    do_reset(3);
    x_in = 16'h0000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      sum += int'(out_valid);
    end
    in_valid = 1'b0;
    tick();
    check("zero_one_per_cycle", sum, 16);
    check("zero_count", log_code.size(), 16);
    check("zero_valid_falls", 32'(out_valid), 0);
    oor = 0;
    foreach (log_code[i]) if (log_code[i] != 0 || log_sat[i]) oor++;
    check("zero_codes", oor, 0);

    // DC 0x0800: first codes and long-run mean. NTF(1)=2-C1 is small but nonzero,
    // so the mean sits slightly below 0.5; the window is set wide enough for that.
    do_reset(3);
    stream(16'h0800, 1024);
    drain();
    check("dc_count", log_code.size(), 1024);
    check("dc_c0", log_code[0], 0);
    check("dc_c1", log_code[1], 1);
    check("dc_c2", log_code[2], 0);
    sum = 0;
    foreach (log_code[i]) sum += log_code[i];
    check("dc_mean_range", 32'(sum >= 384 && sum <= 640), 1);
    ref3 = log_code;

    // Same stream with a 5-cycle output stall after the 2nd code.
    do_reset(3);
    x_in = 16'h0800;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_code", 32'($signed(code)), 1);
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_valid", 32'(out_valid), 1);
      tick();
    end
    stream(16'h0800, 18);
    drain();
    check("stall_count", log_code.size(), 20);
    oor = 0;
    for (int i = 0; i < 20; i++) if (log_code[i] != ref3[i]) oor++;
    check("stall_seq_match", oor, 0);

    // Positive full scale: saturation with clamped error.
    do_reset(3);
    stream(16'h7FFF, 64);
    drain();
    check("fs_count", log_code.size(), 64);
    check("fs_c0", log_code[0], 7);
    check("fs_s0", 32'(log_sat[0]), 0);
    check("fs_c1", log_code[1], 7);
    check("fs_s1", 32'(log_sat[1]), 1);
    oor = 0;
    foreach (log_code[i]) if (log_code[i] > 7 || log_code[i] < -8) oor++;
    check("fs_range", oor, 0);

    // Negative full scale.
    do_reset(3);
    stream(16'h8000, 64);
    drain();
    check("nfs_c0", log_code[0], -8);
    check("nfs_count", log_code.size(), 64);

    // Reset while a code is pending.
    do_reset(3);
    x_in = 16'h0800;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    check("mid_valid_before", 32'(out_valid), 1);
    reset = 1'b1;
    tick();
    check("mid_valid_after", 32'(out_valid), 0);
    check("mid_code_after", 32'(code), 0);
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    log_code.delete();
    log_sat.delete();
    stream(16'h0800, 3);
    drain();
    check("mid_count", log_code.size(), 3);
    check("mid_c0", log_code[0], 0);
    check("mid_c1", log_code[1], 1);
    check("mid_c2", log_code[2], 0);

    // Random samples with random valid/ready.
    do_reset(3);
    for (int i = 0; i < 600; i++) begin
      x_in = 16'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    check("rand_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
